// File: rtl/serial_bus_master.sv
// Serial bus master: arbitrates for the shared bus, shifts out a mode/address/data
// frame, then waits for a write acknowledge or collects an 8-bit read response.
module serial_bus_master #(
    parameter int ADDR_WIDTH  = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            instruction,
    input  logic [7:0]            data_in,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    output logic                  tx_done,
    output logic                  tx_err,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  m_dout,
    output logic                  m_dvalid,
    input  logic                  m_din,
    input  logic                  s_dvalid,
    input  logic                  m_ack
);

    localparam int FRAME_W = 1 + ADDR_WIDTH + 8;
    localparam int RD_W    = 1 + ADDR_WIDTH;
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int TW      = $clog2(ACK_TIMEOUT + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1);

    localparam logic [BW-1:0] LAST_WR = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] LAST_RD = BW'(RD_W - 1);
    localparam logic [BW-1:0] LAST_RX = BW'(7);

    typedef enum logic [2:0] {
        IDLE, REQ, SHIFT, WAIT_ACK, RDATA, DONE, REARM
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic [TW-1:0]           tmo_q, tmo_d, tmo_nx;
    logic [RW-1:0]           retry_q, retry_d, retry_nx;
    logic                    err_q, err_d;
    logic                    gap_q, gap_d;
    logic                    got_q, got_d;
    logic [6:0]              rxsh_q, rxsh_d;
    logic [7:0]              rx_data_q, rx_data_d;
    logic                    fail;
    logic                    last_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            frame_q   <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            gap_q     <= 1'b0;
            got_q     <= 1'b0;
            rxsh_q    <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
            got_q     <= got_d;
            rxsh_q    <= rxsh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign tmo_nx   = tmo_q + 1'b1;
    assign retry_nx = retry_q + 1'b1;
    assign last_bit = (bcnt_q == (wr_q ? LAST_WR : LAST_RD));

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        frame_d   = frame_q;
        bcnt_d    = bcnt_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        err_d     = err_q;
        gap_d     = gap_q;
        got_d     = got_q;
        rxsh_d    = rxsh_q;
        rx_data_d = rx_data_q;
        fail      = 1'b0;

        case (state_q)
            IDLE: begin
                if (instruction == 2'b10 || instruction == 2'b01) begin
                    wr_d    = (instruction == 2'b10);
                    addr_d  = target_addr;
                    data_d  = data_in;
                    retry_d = '0;
                    err_d   = 1'b0;
                    gap_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // gap_q holds bus_req low for the single cycle after a failed attempt
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (bus_grant) begin
                    frame_d = {wr_q, addr_q, data_q};
                    bcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus_grant) begin
                    fail = 1'b1;
                end else if (last_bit) begin
                    bcnt_d  = '0;
                    tmo_d   = '0;
                    got_d   = 1'b0;
                    rxsh_d  = '0;
                    state_d = wr_q ? WAIT_ACK : RDATA;
                end else begin
                    frame_d = frame_q << 1;
                    bcnt_d  = bcnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (!bus_grant) begin
                    fail = 1'b1;
                end else if (m_ack) begin
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_nx;
                    if (tmo_nx == TW'(ACK_TIMEOUT)) fail = 1'b1;
                end
            end
            RDATA: begin
                if (!bus_grant) begin
                    fail = 1'b1;
                end else if (s_dvalid) begin
                    rxsh_d = {rxsh_q[5:0], m_din};
                    got_d  = 1'b1;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_RX) begin
                        rx_data_d = {rxsh_q, m_din};
                        state_d   = DONE;
                    end
                end else if (!got_q) begin
                    tmo_d = tmo_nx;
                    if (tmo_nx == TW'(ACK_TIMEOUT)) fail = 1'b1;
                end
            end
            DONE:  state_d = REARM;
            REARM: if (instruction == 2'b00) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail) begin
            retry_d = retry_nx;
            rxsh_d  = '0;
            got_d   = 1'b0;
            bcnt_d  = '0;
            if (retry_nx == RW'(MAX_RETRY)) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                gap_d   = 1'b1;
                state_d = REQ;
            end
        end
    end

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    assign bus_req  = (state_q == REQ && !gap_q) || state_q == SHIFT ||
                      state_q == WAIT_ACK || state_q == RDATA;
    assign m_dvalid = (state_q == SHIFT) && bus_grant;
    assign m_dout   = m_dvalid & frame_q[FRAME_W-1];
    assign tx_done  = (state_q == DONE);
    assign tx_err   = (state_q == DONE) && err_q;
    assign rx_valid = (state_q == DONE) && !err_q && !wr_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: expected frame bits and completion
// responses are queued by the stimulus and consumed by a monitor.
module tb_serial_bus_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] instruction = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic [1:0] target_addr = 2'b00;
    logic       bus_grant = 1'b0;
    logic       m_din = 1'b0;
    logic       s_dvalid = 1'b0;
    logic       m_ack = 1'b0;
    logic       tx_done, tx_err, rx_valid, bus_req, m_dout, m_dvalid;
    logic [7:0] rx_data;

    int checks = 0, errors = 0, bits_seen = 0, done_seen = 0;
    logic       exp_bits[$];
    logic [9:0] exp_done[$];
    logic [7:0] rx_model = 8'h00;

    serial_bus_master #(.ADDR_WIDTH(2), .ACK_TIMEOUT(16), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .data_in(data_in),
        .target_addr(target_addr), .tx_done(tx_done), .tx_err(tx_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .bus_req(bus_req),
        .bus_grant(bus_grant), .m_dout(m_dout), .m_dvalid(m_dvalid),
        .m_din(m_din), .s_dvalid(s_dvalid), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_frame(logic wr, logic [1:0] a, logic [7:0] d, int n);
        logic [10:0] f;
        int len;
        f   = {wr, a, d};
        len = wr ? 11 : 3;
        for (int i = 0; i < n && i < len; i++) exp_bits.push_back(f[10-i]);
    endfunction

    // Monitor: every qualified bit and every completion pulse is checked against the queues.
    always @(negedge clk) begin
        if (!reset && m_dvalid) begin
            bits_seen++;
            if (exp_bits.size() == 0) begin
                checks++; errors++;
                $display("FAIL bit_unexpected actual=%0b expected=none", m_dout);
            end else chk("frame_bit", {31'd0, m_dout}, {31'd0, exp_bits.pop_front()});
        end
        if (!reset && tx_done) begin
            done_seen++;
            if (exp_done.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected actual=%0h expected=none", {tx_err, rx_valid, rx_data});
            end else chk("done_resp", {22'd0, tx_err, rx_valid, rx_data}, {22'd0, exp_done.pop_front()});
        end
    end

    task automatic wait_bits(int target);
        for (int i = 0; i < 200 && bits_seen < target; i++) tick();
        chk("bits_reached", bits_seen, target);
    endtask

    task automatic wait_done(int target);
        for (int i = 0; i < 400 && done_seen < target; i++) tick();
        chk("done_reached", done_seen, target);
        chk("done_one_cycle", tx_done, 0);
    endtask

    task automatic release_instr();
        instruction = 2'b00;
        tick();
        tick();
        chk("idle_req", bus_req, 0);
    endtask

    task automatic run_write(logic [7:0] d, logic [1:0] a, int gdly, int adly);
        int b0, d0;
        push_frame(1'b1, a, d, 11);
        exp_done.push_back({2'b00, rx_model});
        b0 = bits_seen + 11;
        d0 = done_seen + 1;
        bus_grant   = (gdly == 0);
        instruction = 2'b10;
        data_in     = d;
        target_addr = a;
        tick();
        for (int i = 0; i < gdly; i++) begin
            chk("req_wait_grant", bus_req, 1);
            tick();
        end
        bus_grant = 1'b1;
        wait_bits(b0);
        repeat (adly) tick();
        chk("req_wait_ack", bus_req, 1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        wait_done(d0);
    endtask

    initial begin
        int b0, d0, low, started;
        logic [7:0] v;
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int b0, d0, low, started;
        logic [7:0] v;

        tick();
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_dvalid", m_dvalid, 0);
        reset = 1'b0;
        tick();
        chk("rst_outputs", {tx_done, tx_err, rx_valid, m_dout}, 0);
        chk("rst_rx_data", rx_data, 0);

        // write A5 to address 01, grant after 3 cycles, ack 2 cycles after frame
        run_write(8'hA5, 2'b01, 3, 2);
        release_instr();

        // read from address 10, slave returns 3C with a gap after bit 4
        push_frame(1'b0, 2'b10, 8'h00, 3);
        rx_model = 8'h3C;
        exp_done.push_back({2'b01, 8'h3C});
        b0 = bits_seen + 3;
        d0 = done_seen + 1;
        bus_grant = 1'b1;
        instruction = 2'b01;
        target_addr = 2'b10;
        tick();
        wait_bits(b0);
        v = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                s_dvalid = 1'b0;
                tick();
            end
            s_dvalid = 1'b1;
            m_din = v[7-i];
            tick();
        end
        s_dvalid = 1'b0;
        m_din = 1'b0;
        wait_done(d0);
        release_instr();

        // held instruction must not restart until it goes back to idle
        run_write(8'h5A, 2'b11, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_no_req", bus_req, 0);
        end
        release_instr();
        run_write(8'h0F, 2'b00, 0, 0);
        release_instr();

        // no ack: three frames, one-cycle bus_req gaps, then done with error
        for (int k = 0; k < 3; k++) push_frame(1'b1, 2'b10, 8'hC3, 11);
        exp_done.push_back({2'b10, rx_model});
        b0 = bits_seen + 33;
        d0 = done_seen + 1;
        low = 0;
        started = 0;
        bus_grant = 1'b1;
        instruction = 2'b10;
        data_in = 8'hC3;
        target_addr = 2'b10;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx_done) break;
            if (bus_req) started = 1;
            else if (started != 0) low++;
        end
        chk("retry_gaps", low, 2);
        chk("retry_tx_err", tx_err, 1);
        chk("retry_frames", bits_seen, b0);
        wait_done(d0);
        release_instr();

        // grant lost at data bit 3; retry resends the latched frame
        push_frame(1'b1, 2'b01, 8'h96, 6);
        push_frame(1'b1, 2'b01, 8'h96, 11);
        exp_done.push_back({2'b00, rx_model});
        b0 = bits_seen;
        bus_grant = 1'b1;
        instruction = 2'b10;
        data_in = 8'h96;
        target_addr = 2'b01;
        tick();
        data_in = 8'hFF;
        target_addr = 2'b10;
        wait_bits(b0 + 6);
        bus_grant = 1'b0;
        #1;
        chk("abort_dvalid", m_dvalid, 0);
        tick();
        chk("abort_gap", bus_req, 0);
        bus_grant = 1'b1;
        wait_bits(b0 + 17);
        d0 = done_seen + 1;
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        wait_done(d0);
        release_instr();

        // reset in the middle of a frame
        push_frame(1'b1, 2'b00, 8'h11, 4);
        b0 = bits_seen + 4;
        bus_grant = 1'b1;
        instruction = 2'b10;
        data_in = 8'h11;
        target_addr = 2'b00;
        tick();
        wait_bits(b0);
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {bus_req, m_dvalid, tx_done}, 0);
        instruction = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        rx_model = 8'h00;
        chk("midrst_rx_data", rx_data, 0);
        tick();
        run_write(8'hE1, 2'b11, 1, 1);
        release_instr();

        chk("bits_queue_empty", exp_bits.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
